// File: rtl/sipo_frame_ctrl.sv
// Frame sequencer for a SIPO shift register.
// Clears, shifts WIDTH bits on a prescaled enable, captures, then hands off.
module sipo_frame_ctrl #(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 50_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [WIDTH-1:0]           sipo_q,
  output logic                       sipo_clr,
  output logic                       sipo_shift,
  output logic                       busy,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
  output logic [WIDTH-1:0]           frame_data,
  output logic                       frame_valid,
  input  logic                       frame_ready,
  output logic                       overrun
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] WMAX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SHIFT,
    CAPTURE
  } state_t;

  state_t          state, state_n;
  logic [PW-1:0]   pre, pre_n;
  logic [CW-1:0]   cnt_n;
  logic            clr_n, shift_n, busy_n;
  logic            valid_n, ovr_n;
  logic [WIDTH-1:0] data_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pre         <= '0;
      bit_cnt     <= '0;
      sipo_clr    <= 1'b0;
      sipo_shift  <= 1'b0;
      busy        <= 1'b0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_n;
      pre         <= pre_n;
      bit_cnt     <= cnt_n;
      sipo_clr    <= clr_n;
      sipo_shift  <= shift_n;
      busy        <= busy_n;
      frame_data  <= data_n;
      frame_valid <= valid_n;
      overrun     <= ovr_n;
    end
  end

  always_comb begin
    state_n = state;
    pre_n   = pre;
    cnt_n   = bit_cnt;
    clr_n   = 1'b0;
    data_n  = frame_data;
    valid_n = frame_valid;
    ovr_n   = overrun;
    if (frame_valid && frame_ready)
      valid_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = CLEAR;
          clr_n   = 1'b1;
          cnt_n   = '0;
          pre_n   = '0;
        end
      end
      CLEAR: begin
        state_n = SHIFT;
        pre_n   = '0;
      end
      SHIFT: begin
        if (pre == PMAX) begin
          pre_n = '0;
          cnt_n = bit_cnt + CW'(1);
          if (bit_cnt == WMAX)
            state_n = CAPTURE;
        end else begin
          pre_n = pre + PW'(1);
        end
      end
      CAPTURE: begin
        data_n  = sipo_q;
        valid_n = 1'b1;
        // Overwriting a word nobody took is the only overrun case
        if (frame_valid && !frame_ready)
          ovr_n = 1'b1;
        state_n = IDLE;
      end
    endcase
    // Outputs are registered, so decode them from the next state
    shift_n = (state_n == SHIFT) && (pre_n == PMAX);
    busy_n  = (state_n != IDLE);
  end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench for sipo_frame_ctrl.
// Covers frame timing, handshake, overrun, reset abort and TICK_DIV=1.
module tb_sipo_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] sq;
  logic       clr, shift, busy, valid, ovr;
  logic [3:0] cnt;
  logic [7:0] data;

  logic       start_b = 1'b0;
  logic [7:0] sq_b = 8'hC3;
  logic       clr_b, shift_b, busy_b, valid_b, ovr_b;
  logic [3:0] cnt_b;
  logic [7:0] data_b;

  logic [7:0] pat = 8'h00;
  logic [2:0] idx = 3'd0;
  int         n_chk = 0;
  int         n_fail = 0;
  int         n;

  always #5 clk = ~clk;

  sipo_frame_ctrl #(.WIDTH(8), .TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sipo_q(sq),
    .sipo_clr(clr), .sipo_shift(shift), .busy(busy),
    .bit_cnt(cnt), .frame_data(data), .frame_valid(valid),
    .frame_ready(ready), .overrun(ovr)
  );

  sipo_frame_ctrl #(.WIDTH(8), .TICK_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .sipo_q(sq_b),
    .sipo_clr(clr_b), .sipo_shift(shift_b), .busy(busy_b),
    .bit_cnt(cnt_b), .frame_data(data_b), .frame_valid(valid_b),
    .frame_ready(1'b0), .overrun(ovr_b)
  );

  // SIPO model: serial bits from pat, MSB first
  always @(posedge clk) begin
    if (clr) begin
      sq  <= 8'h00;
      idx <= 3'd0;
    end else if (shift) begin
      sq  <= {sq[6:0], pat[3'd7 - idx]};
      idx <= idx + 3'd1;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [7:0] p);
    pat   = p;
    start = 1'b1;
    step;
    start = 1'b0;
    repeat (34) step;
  endtask

  initial begin
    sq = 8'h00;
    step;
    step;
    rst = 1'b0;
    chk("rst_clr", clr, 0);
    chk("rst_shift", shift, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_data", data, 0);
    chk("rst_valid", valid, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_b_busy", busy_b, 0);

    // basic frame, cycle c is T+c
    pat   = 8'hB2;
    start = 1'b1;
    step;
    start = 1'b0;
    for (int c = 1; c <= 36; c++) begin
      chk($sformatf("clr@%0d", c), clr, c == 1);
      chk($sformatf("shift@%0d", c), shift,
          (c >= 5) && (c <= 33) && ((c - 1) % 4 == 0));
      chk($sformatf("busy@%0d", c), busy, c <= 34);
      chk($sformatf("valid@%0d", c), valid, c >= 35);
      chk($sformatf("cnt@%0d", c), cnt,
          (c < 2) ? 0 : (((c - 2) / 4 > 8) ? 8 : (c - 2) / 4));
      step;
    end
    chk("basic_data", data, 8'hB2);
    chk("basic_ovr", ovr, 0);

    // handshake
    ready = 1'b1;
    step;
    ready = 1'b0;
    chk("hs_valid", valid, 0);
    chk("hs_data", data, 8'hB2);
    chk("hs_ovr", ovr, 0);

    // overrun
    run_frame(8'h3C);
    chk("ov1_valid", valid, 1);
    chk("ov1_data", data, 8'h3C);
    chk("ov1_ovr", ovr, 0);
    run_frame(8'h5C);
    chk("ov2_valid", valid, 1);
    chk("ov2_data", data, 8'h5C);
    chk("ov2_ovr", ovr, 1);
    ready = 1'b1;
    step;
    ready = 1'b0;
    chk("ov3_valid", valid, 0);
    chk("ov3_ovr", ovr, 1);
    step;
    chk("ov4_ovr", ovr, 1);
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("ov_rst", ovr, 0);

    // capture coincides with accept
    run_frame(8'hA5);
    chk("sim1_data", data, 8'hA5);
    pat   = 8'h69;
    start = 1'b1;
    step;
    start = 1'b0;
    repeat (33) step;
    ready = 1'b1;
    step;
    ready = 1'b0;
    chk("sim_valid", valid, 1);
    chk("sim_data", data, 8'h69);
    chk("sim_ovr", ovr, 0);

    // reset mid-shift
    pat   = 8'hFF;
    start = 1'b1;
    step;
    start = 1'b0;
    for (int i = 0; i < 40 && cnt != 4'd3; i++) step;
    chk("mid_cnt3", cnt, 3);
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("mid_clr", clr, 0);
    chk("mid_shift", shift, 0);
    chk("mid_busy", busy, 0);
    chk("mid_cnt", cnt, 0);
    chk("mid_data", data, 0);
    chk("mid_valid", valid, 0);
    chk("mid_ovr", ovr, 0);
    n = 0;
    repeat (40) begin
      if (shift) n++;
      step;
    end
    chk("mid_noshift", n, 0);
    pat   = 8'h96;
    start = 1'b1;
    step;
    start = 1'b0;
    n = 0;
    repeat (36) begin
      if (shift) n++;
      step;
    end
    chk("mid_pulses", n, 8);
    chk("mid_newdata", data, 8'h96);
    chk("mid_newvalid", valid, 1);

    // TICK_DIV=1, start held high: period 11
    start_b = 1'b1;
    step;
    for (int c = 1; c <= 33; c++) begin
      int m;
      m = (c - 1) % 11;
      chk($sformatf("b_clr@%0d", c), clr_b, m == 0);
      chk($sformatf("b_shift@%0d", c), shift_b, (m >= 1) && (m <= 8));
      chk($sformatf("b_busy@%0d", c), busy_b, m != 10);
      chk($sformatf("b_cnt@%0d", c), cnt_b,
          (m == 0) ? 0 : ((m == 10) ? 8 : m - 1));
      step;
    end
    start_b = 1'b0;
    chk("b_data", data_b, 8'hC3);
    chk("b_valid", valid_b, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sipo_frame_ctrl.md
Name: sipo_frame_ctrl

Overview:
Sequencing controller for the serial-in/parallel-out shift register. It clears the SIPO, issues one shift-enable pulse per bit period from an internal prescaler, counts WIDTH bits, captures the SIPO parallel word, and presents it downstream on a valid/ready handshake. It replaces free-running divided clocks with single-clock enables. A capture that finds the previous frame still unaccepted is flagged as an overrun.

Parameters:
WIDTH, 8, SIPO word width / bits per frame (>= 2)
TICK_DIV, 50_000_000, clk cycles per bit period (>= 1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  begin a frame; sampled only in IDLE
sipo_q  input  WIDTH  parallel output of the SIPO register
sipo_clr  output  1  one-cycle clear pulse to the SIPO
sipo_shift  output  1  one-cycle shift-enable pulse to the SIPO
busy  output  1  high in every state except IDLE
bit_cnt  output  $clog2(WIDTH+1)  shift pulses issued in the current frame
frame_data  output  WIDTH  captured word
frame_valid  output  1  frame_data holds an unaccepted word
frame_ready  input  1  downstream accepts the word
overrun  output  1  sticky: a capture occurred while frame_valid=1 and frame_ready=0

Behaviour:
- Reset: synchronous, highest priority. State=IDLE, prescaler=0, bit_cnt=0, sipo_clr=0, sipo_shift=0, busy=0, frame_data=0, frame_valid=0, overrun=0. Reset mid-frame aborts the frame with no capture.
- Only rst clears overrun.
- FSM states: IDLE, CLEAR, SHIFT, CAPTURE. All outputs are registered.
- IDLE: busy=0. If start=1 at cycle T, enter CLEAR.
- CLEAR (cycle T+1): sipo_clr=1, bit_cnt=0, prescaler=0. Unconditionally enter SHIFT.
- SHIFT (from T+2):
  - Prescaler counts 0..TICK_DIV-1.
  - In the cycle the prescaler equals TICK_DIV-1: sipo_shift=1, prescaler wraps to 0, and bit_cnt increments on the next edge.
  - The k-th pulse (k=1..WIDTH) occurs at cycle T+1+k*TICK_DIV.
  - After the WIDTH-th pulse, enter CAPTURE.
  - With TICK_DIV=1, sipo_shift is high on every SHIFT cycle.
- CAPTURE (cycle T+2+WIDTH*TICK_DIV):
  - frame_data <= sipo_q; frame_valid <= 1, visible from T+3+WIDTH*TICK_DIV.
  - Return to IDLE.
  - bit_cnt holds WIDTH until the next CLEAR.
  - Frame latency from start to frame_valid is WIDTH*TICK_DIV+3 cycles.
- start is ignored while busy=1, including during CAPTURE. It is level-sampled: start held high re-triggers a new frame on the first IDLE cycle after each capture.
- Handshake:
  - Transfer occurs when frame_valid=1 and frame_ready=1 at a rising edge; frame_valid falls on that edge.
  - frame_data is stable while frame_valid=1, except when overwritten by a capture.
  - frame_ready is don't-care when frame_valid=0.
- Capture coinciding with a transfer: the new word loads, frame_valid stays 1, overrun is not set.
- Capture while frame_valid=1 and frame_ready=0: the new word overwrites frame_data, frame_valid stays 1, overrun is set to 1 (sticky).
- sipo_clr and sipo_shift are never high in the same cycle. Exactly WIDTH shift pulses are issued per completed frame.
- Prescaler and bit_cnt widths are sized from the parameters; no wrap occurs except the prescaler at TICK_DIV-1.

Test Plan:
- Basic frame (WIDTH=8, TICK_DIV=4, frame_ready=0, SIPO model shifting serial 1,0,1,1,0,0,1,0 MSB-first): start pulse at T -> sipo_clr at T+1; sipo_shift at T+5,T+9,...,T+33; frame_data=8'hB2; frame_valid high at T+35; busy low from T+35.
- Handshake: frame pending, frame_ready=1 for one cycle -> frame_valid falls next edge; frame_data unchanged; overrun=0.
- Overrun: second frame completes with frame_valid=1 and frame_ready=0 -> frame_data=new word, overrun=1; overrun stays 1 after a later accept; cleared only by rst.
- Simultaneous capture and accept (frame_ready=1 on the capture cycle) -> frame_valid stays 1 with new data; overrun=0.
- Reset mid-SHIFT (rst at bit_cnt=3) -> next cycle all outputs 0 and state IDLE; no further sipo_shift; a new start produces a full 8-pulse frame.
- Edge params (TICK_DIV=1, start held high continuously) -> 8 consecutive sipo_shift cycles per frame; back-to-back frames with start-to-start period 11 cycles; start asserted during busy does not disturb bit_cnt.
